booth_mac_ctrl: RTL and testbench
=================================

# booth_mac_ctrl

Operand sequencer and accumulator placed directly around the 16-bit Booth multiplier (`multi_booth_16bit`). It accepts signed operand pairs over a valid/ready stream and launches one multiplication per pair by pulsing the multiplier's reset/start input. It waits for the multiplier's `rdy` and sign-extends each 32-bit product into a running accumulator. On the pair flagged `in_last` it presents the dot-product result over a valid/ready output.

## Interface
- `WIDTH`, 16: operand width (product is 2*WIDTH).
- `ACC_W`, 40: accumulator width (must be ≥ 2*WIDTH).
- `CNT_W`, 8: product-counter width.
- `TIMEOUT`, 63: maximum WAIT cycles before abort.

- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  block can accept a pair.
- `in_a`, `in_b`  in  WIDTH  signed operands.
- `in_last`  in  1  final pair of the current sequence.
- `mul_start`  out  1  drives the multiplier's `reset` pin; one-cycle pulse.
- `mul_a`, `mul_b`  out  WIDTH  registered operands to the multiplier.
- `mul_p`  in  2*WIDTH  signed product from the multiplier.
- `mul_rdy`  in  1  multiplier done.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_acc`  out  ACC_W  signed accumulated sum.
- `out_count`  out  CNT_W  number of products accumulated; saturates at all-ones.
- `out_ovf`  out  1  sticky signed overflow of the accumulator.
- `out_err`  out  1  sequence aborted by timeout.

## Operation
- States: IDLE, LAUNCH, WAIT, OUT. Reset enters IDLE.
- **IDLE:**
  - `in_ready` = 1.
  - On `in_valid && in_ready`, register `in_a`/`in_b` into `mul_a`/`mul_b` and register `in_last`.
  - Set `mul_start` = 1 and go to LAUNCH.
- **LAUNCH:**
  - `mul_start` is high for exactly this one cycle and is cleared at the next edge.
  - Go to WAIT and clear the timeout counter.
- **WAIT:**
  - `mul_a` and `mul_b` are held stable.
  - At the first edge where `mul_rdy` = 1:
    - `acc` <= `acc` + sign-extended `mul_p`. The sum wraps in two's complement.
    - `out_ovf` is set if the signed addition overflows ACC_W. Once set it stays set until the result is taken.
    - `out_count` increments and saturates at all-ones.
    - Go to OUT if the registered last flag is set, otherwise go to IDLE.
- **Timeout in WAIT:**
  - If `mul_rdy` has not been seen after TIMEOUT cycles, set `out_err`.
  - The product is discarded and `out_count` is not incremented.
  - Go to OUT regardless of the last flag.
- **OUT:**
  - `out_valid` = 1. `out_acc`, `out_count`, `out_ovf` and `out_err` are stable.
  - On `out_valid && out_ready`, clear `acc`, `out_count`, `out_ovf` and `out_err`, then go to IDLE.
- `in_ready` is 0 in LAUNCH, WAIT and OUT, so no pair is accepted while a multiplication or a pending result is outstanding.
- Reset asserted in any state:
  - The in-flight pair and the partial sum are lost.
  - All registers return to reset values immediately, without waiting for a clock.

## Timing
- **Reset values:**
  - `in_ready` = 0 while `reset` is high, and 1 from the first cycle after release.
  - All other outputs (`mul_start`, `mul_a`, `mul_b`, `out_valid`, `out_acc`, `out_count`, `out_ovf`, `out_err`) are 0.
- Handshake at edge k:
  - `mul_start` is high from k to k+1.
  - The multiplier samples its reset high at edge k+1.
  - The state is WAIT from k+1 onward.
- If `mul_rdy` is sampled high at edge m:
  - The accumulator update is visible after edge m.
  - `out_valid` rises after edge m when the pair was last.
- The next pair can be accepted at edge m+1 when the pair was not last.
- Per-pair cost is 2 + multiplier latency cycles.
- `mul_rdy` is ignored outside WAIT.
- If `mul_rdy` and the timeout expire at the same edge, `mul_rdy` wins.
- `out_valid` stays high with stable data under `out_ready` = 0 for any number of cycles.

## Test plan
- **Single pair:** pair (3, −4) with last → `out_acc` = −12, `out_count` = 1, `out_ovf` = 0, `out_err` = 0; `mul_start` is one cycle wide.
- **Three-pair sequence:** (100, 200), (−300, 7), (32767, 32767) with last on the third → `out_acc` = 1073694189, `out_count` = 3.
- **Output backpressure:** hold `out_ready` = 0 for 5 cycles in OUT → `out_valid`, `out_acc` and `out_count` stay unchanged and `in_ready` = 0. Release → result is taken, and the next sequence starts from `acc` = 0.
- **Overflow (ACC_W = 32):** two pairs of (−32768, −32768) → `out_acc` = −2147483648 (wrapped) and `out_ovf` = 1.
- **Timeout:** stub `mul_rdy` at 0 → `out_valid` is asserted after 63 WAIT cycles with `out_err` = 1, `out_count` = 0, `out_acc` = 0.
- **Reset mid-WAIT:**
  - Assert `reset` asynchronously (between clock edges) → all outputs go to their reset values.
  - After release, a new sequence (5, 6) with last → `out_acc` = 30.

Source files
------------

// File: rtl/booth_mac_ctrl_if.sv
// Operand stream, multiplier link and result stream of booth_mac_ctrl.
// The slave modport is the controller's view; master is the surrounding logic's.
interface booth_mac_ctrl_if #(
    parameter int WIDTH = 16,
    parameter int ACC_W = 40,
    parameter int CNT_W = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic                 in_last;
    logic                 mul_start;
    logic [WIDTH-1:0]     mul_a;
    logic [WIDTH-1:0]     mul_b;
    logic [2*WIDTH-1:0]   mul_p;
    logic                 mul_rdy;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_W-1:0]     out_acc;
    logic [CNT_W-1:0]     out_count;
    logic                 out_ovf;
    logic                 out_err;

    modport master (
        output in_valid, in_a, in_b, in_last, mul_p, mul_rdy, out_ready,
        input  in_ready, mul_start, mul_a, mul_b,
               out_valid, out_acc, out_count, out_ovf, out_err
    );

    modport slave (
        input  in_valid, in_a, in_b, in_last, mul_p, mul_rdy, out_ready,
        output in_ready, mul_start, mul_a, mul_b,
               out_valid, out_acc, out_count, out_ovf, out_err
    );
endinterface

// File: rtl/booth_mac_ctrl.sv
// Sequences signed operand pairs through the Booth multiplier and accumulates
// the products into a dot-product result with overflow and timeout flags.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | ready for an operand pair
// S_LAUNCH | mul_start high for one cycle, multiplier is being restarted
// S_WAIT   | waiting for mul_rdy, timeout down-counter running
// S_OUT    | result presented until taken
module booth_mac_ctrl #(
    parameter int WIDTH   = 16,
    parameter int ACC_W   = 40,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 63
) (
    input  logic              clk,
    input  logic              reset,
    booth_mac_ctrl_if.slave   bus
);
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_OUT} state_t;

    state_t state_q, state_d;

    logic                     ready_q;
    logic                     mul_start_q;
    logic [WIDTH-1:0]         mul_a_q;
    logic [WIDTH-1:0]         mul_b_q;
    logic                     last_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic [CNT_W-1:0]         cnt_q;
    logic                     ovf_q;
    logic                     err_q;
    logic [TMR_W-1:0]         tmr_q;

    logic accept, mac_en, tmo, clr;

    logic signed [2*WIDTH-1:0] prod_s;
    logic signed [ACC_W-1:0]   prod_ext;
    logic signed [ACC_W-1:0]   acc_sum;
    logic                      ovf_now;

    assign prod_s   = bus.mul_p;
    assign prod_ext = ACC_W'(prod_s);
    assign acc_sum  = acc_q + prod_ext;
    // Signed overflow: both addends share a sign that the sum does not.
    assign ovf_now  = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) &&
                      (acc_sum[ACC_W-1] != acc_q[ACC_W-1]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        mac_en  = 1'b0;
        tmo     = 1'b0;
        clr     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid && ready_q) begin
                    accept  = 1'b1;
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A product arriving on the expiry edge still counts.
                if (bus.mul_rdy) begin
                    mac_en  = 1'b1;
                    state_d = last_q ? S_OUT : S_IDLE;
                end else if (tmr_q == '0) begin
                    tmo     = 1'b1;
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (bus.out_ready) begin
                    clr     = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_q     <= 1'b0;
            mul_start_q <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            last_q      <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
            tmr_q       <= '0;
        end else begin
            ready_q     <= (state_d == S_IDLE);
            mul_start_q <= accept;
            if (accept) begin
                mul_a_q <= bus.in_a;
                mul_b_q <= bus.in_b;
                last_q  <= bus.in_last;
            end
            if (state_q == S_LAUNCH) begin
                tmr_q <= TMR_LOAD;
            end else if (state_q == S_WAIT && tmr_q != '0) begin
                tmr_q <= tmr_q - 1'b1;
            end
            if (mac_en) begin
                acc_q <= acc_sum;
                ovf_q <= ovf_q | ovf_now;
                if (cnt_q != '1) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
            if (tmo) begin
                err_q <= 1'b1;
            end
            if (clr) begin
                acc_q <= '0;
                cnt_q <= '0;
                ovf_q <= 1'b0;
                err_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = ready_q;
    assign bus.mul_start = mul_start_q;
    assign bus.mul_a     = mul_a_q;
    assign bus.mul_b     = mul_b_q;
    assign bus.out_valid = (state_q == S_OUT);
    assign bus.out_acc   = acc_q;
    assign bus.out_count = cnt_q;
    assign bus.out_ovf   = ovf_q;
    assign bus.out_err   = err_q;
endmodule

// File: tb/tb_booth_mac_ctrl.sv
// Directed bench for booth_mac_ctrl with a behavioural multiplier and a
// result scoreboard; accumulator narrowed to 32 bits to reach overflow.
module tb_booth_mac_ctrl;
    localparam int WIDTH = 16;
    localparam int ACC_W = 32;
    localparam int CNT_W = 8;

    typedef struct {
        logic [31:0] acc;
        logic [7:0]  cnt;
        logic        ovf;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    booth_mac_ctrl_if #(.WIDTH(WIDTH), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

    booth_mac_ctrl #(.WIDTH(WIDTH), .ACC_W(ACC_W), .CNT_W(CNT_W), .TIMEOUT(63)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          lat = 3;
    logic        rdy_en = 1'b1;
    logic        m_rdy;
    logic        m_busy;
    int          m_cnt;
    logic signed [31:0] m_p;

    assign bus.mul_rdy = m_rdy;
    assign bus.mul_p   = m_p;

    // Multiplier stand-in: restarted by mul_start, rdy after lat cycles, held.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_rdy  <= 1'b0;
            m_busy <= 1'b0;
            m_cnt  <= 0;
            m_p    <= '0;
        end else if (bus.mul_start) begin
            m_rdy  <= 1'b0;
            m_busy <= 1'b1;
            m_cnt  <= lat;
        end else if (m_busy) begin
            if (m_cnt <= 1) begin
                m_busy <= 1'b0;
                m_rdy  <= rdy_en;
                m_p    <= $signed(bus.mul_a) * $signed(bus.mul_b);
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    int     n_cmp = 0;
    int     n_err = 0;
    exp_t   sb[$];
    longint e_acc = 0;
    int     e_cnt = 0;
    logic   e_ovf = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        e_acc = 0;
        e_cnt = 0;
        e_ovf = 1'b0;
    endtask

    task automatic send(input logic signed [15:0] a, input logic signed [15:0] b,
                        input logic last, input logic upd);
        int n;
        longint wide;
        logic signed [31:0] w32;
        exp_t e;
        n = 0;
        @(negedge clk);
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_last  = last;
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (bus.in_ready !== 1'b1) begin
            chk("in_ready_timeout", {63'd0, bus.in_ready}, 64'd1);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        if (upd) begin
            wide = e_acc + (longint'(a) * longint'(b));
            if (wide > 64'sd2147483647 || wide < -64'sd2147483648) e_ovf = 1'b1;
            w32   = wide[31:0];
            e_acc = w32;
            e_cnt = (e_cnt == 255) ? 255 : e_cnt + 1;
            if (last) begin
                e.acc = w32;
                e.cnt = 8'(e_cnt);
                e.ovf = e_ovf;
                e.err = 1'b0;
                sb.push_back(e);
            end
        end
    endtask

    task automatic take(input string tag, input int hold, input logic [31:0] lit_acc);
        int n;
        exp_t e;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (bus.out_valid !== 1'b1) begin
            chk({tag, "_valid_timeout"}, {63'd0, bus.out_valid}, 64'd1);
            return;
        end
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s_unexpected: observed result with empty scoreboard, required none", tag);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_acc"},      64'(bus.out_acc),   64'(e.acc));
        chk({tag, "_acc_lit"},  64'(bus.out_acc),   64'(lit_acc));
        chk({tag, "_count"},    64'(bus.out_count), 64'(e.cnt));
        chk({tag, "_ovf"},      64'(bus.out_ovf),   64'(e.ovf));
        chk({tag, "_err"},      64'(bus.out_err),   64'(e.err));
        chk({tag, "_in_ready"}, 64'(bus.in_ready),  64'd0);
        if (hold > 0) begin
            bus.out_ready = 1'b0;
            repeat (hold) @(negedge clk);
            chk({tag, "_hold_valid"}, 64'(bus.out_valid), 64'd1);
            chk({tag, "_hold_acc"},   64'(bus.out_acc),   64'(e.acc));
            chk({tag, "_hold_count"}, 64'(bus.out_count), 64'(e.cnt));
            chk({tag, "_hold_ready"}, 64'(bus.in_ready),  64'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk({tag, "_post_valid"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "_post_acc"},   64'(bus.out_acc),   64'd0);
        chk({tag, "_post_count"}, 64'(bus.out_count), 64'd0);
        chk({tag, "_post_flags"}, {62'd0, bus.out_ovf, bus.out_err}, 64'd0);
        model_clear();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t et;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_in_ready",  64'(bus.in_ready),  64'd0);
        chk("rst_mul",       {31'd0, bus.mul_start, bus.mul_a, bus.mul_b}, 64'd0);
        chk("rst_out",       {29'd0, bus.out_valid, bus.out_acc, bus.out_count[1:0], bus.out_ovf, bus.out_err}, 64'd0);
        chk("rst_count",     64'(bus.out_count), 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rel_in_ready",  64'(bus.in_ready),  64'd1);

        // Single pair, one-cycle mul_start
        send(16'sd3, -16'sd4, 1'b1, 1'b1);
        chk("single_start_hi", 64'(bus.mul_start), 64'd1);
        chk("single_mul_a",    64'(bus.mul_a),     64'h0003);
        chk("single_mul_b",    64'(bus.mul_b),     64'hfffc);
        chk("single_busy",     64'(bus.in_ready),  64'd0);
        @(posedge clk);
        #1;
        chk("single_start_lo", 64'(bus.mul_start), 64'd0);
        take("single", 0, 32'hfffffff4);

        // Three-pair dot product
        lat = 5;
        send(16'sd100,   16'sd200,   1'b0, 1'b1);
        send(-16'sd300,  16'sd7,     1'b0, 1'b1);
        send(16'sd32767, 16'sd32767, 1'b1, 1'b1);
        take("seq3", 0, 32'd1073694189);

        // Backpressure, then a fresh sequence from zero
        lat = 2;
        send(16'sd1000, -16'sd1000, 1'b1, 1'b1);
        take("bp", 5, 32'hfff0bdc0);
        send(16'sd2, 16'sd3, 1'b1, 1'b1);
        take("bp_next", 0, 32'd6);

        // Signed overflow in a 32-bit accumulator
        send(-16'sd32768, -16'sd32768, 1'b0, 1'b1);
        send(-16'sd32768, -16'sd32768, 1'b1, 1'b1);
        take("ovf", 0, 32'h80000000);

        // Timeout with a silent multiplier
        rdy_en = 1'b0;
        send(16'sd7, 16'sd9, 1'b1, 1'b0);
        et.acc = 32'd0;
        et.cnt = 8'd0;
        et.ovf = 1'b0;
        et.err = 1'b1;
        sb.push_back(et);
        repeat (63) @(posedge clk);
        #1;
        chk("tmo_not_yet", 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        #1;
        chk("tmo_valid",   64'(bus.out_valid), 64'd1);
        take("tmo", 0, 32'd0);
        rdy_en = 1'b1;

        // Asynchronous reset in the middle of WAIT
        lat = 10;
        send(16'sd9, 16'sd9, 1'b0, 1'b1);
        repeat (4) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("arst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("arst_mul",      {31'd0, bus.mul_start, bus.mul_a, bus.mul_b}, 64'd0);
        chk("arst_out",      {27'd0, bus.out_valid, bus.out_acc, bus.out_ovf, bus.out_err, 2'b00}, 64'd0);
        chk("arst_count",    64'(bus.out_count), 64'd0);
        model_clear();
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("arst_rel_ready", 64'(bus.in_ready), 64'd1);
        lat = 3;
        send(16'sd5, 16'sd6, 1'b1, 1'b1);
        take("arst_next", 0, 32'd30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
